// File: rtl/instr_fetch_pkg.sv
// Shared encodings and default widths for the instruction-fetch stage.
// FSM states are 2-bit localparam constants so legacy decode logic can compare them directly.
package instr_fetch_pkg;

  localparam int D_WIDTH_DEF = 16;
  localparam int A_WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic RAM_READ = 1'b0;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: async clear, load beats increment, increments wrap modulo 2**A_WIDTH.
// Zero latency to pc_o after the edge; no backpressure, the caller decides when to move.
module pc_reg
  import instr_fetch_pkg::*;
#(
  parameter int                 A_WIDTH  = A_WIDTH_DEF,
  parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [A_WIDTH-1:0] load_val_i,
  input  logic               inc_i,
  output logic [A_WIDTH-1:0] pc_o
);

  localparam logic [A_WIDTH-1:0] PC_STEP = {{(A_WIDTH-1){1'b0}}, 1'b1};

  logic [A_WIDTH-1:0] pc_q;
  logic [A_WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk_i or negedge clr_i) begin
    if (!clr_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: reads program RAM at pc, holds the word in the IR and offers it to decode.
// Min 3 cycles per instruction; IR is held stable until ir_ready_i; jmp_en_i squashes any in-flight read.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                 D_WIDTH  = D_WIDTH_DEF,
  parameter int                 A_WIDTH  = A_WIDTH_DEF,
  parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               clr_i,
  output logic               ram_enab_o,
  output logic               ram_rw_o,
  output logic [A_WIDTH-1:0] ram_addr_o,
  input  logic [D_WIDTH-1:0] ram_data_i,
  input  logic               halt_i,
  input  logic               jmp_en_i,
  input  logic [A_WIDTH-1:0] jmp_addr_i,
  output logic               ir_valid_o,
  input  logic               ir_ready_i,
  output logic [D_WIDTH-1:0] ir_data_o,
  output logic [A_WIDTH-1:0] ir_pc_o,
  output logic [A_WIDTH-1:0] pc_out_o
);

  logic [1:0]         state_q, state_d;
  logic               ir_valid_q, ir_valid_d;
  logic [D_WIDTH-1:0] ir_data_q;
  logic [A_WIDTH-1:0] ir_pc_q;
  logic [A_WIDTH-1:0] pc;
  logic               ir_load;
  logic               pc_inc;

  pc_reg #(
    .A_WIDTH  (A_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i      (clk_i),
    .clr_i      (clr_i),
    .load_i     (jmp_en_i),
    .load_val_i (jmp_addr_i),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  // A jump overrides every state, including a pending WAIT load and a HOLD accept.
  always_comb begin
    state_d    = state_q;
    ir_valid_d = ir_valid_q;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    if (jmp_en_i) begin
      state_d    = halt_i ? ST_IDLE : ST_FETCH;
      ir_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:  if (!halt_i) state_d = ST_FETCH;
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT: begin
          state_d    = ST_HOLD;
          ir_load    = 1'b1;
          ir_valid_d = 1'b1;
        end
        default: begin
          if (ir_ready_i) begin
            state_d    = halt_i ? ST_IDLE : ST_FETCH;
            ir_valid_d = 1'b0;
            pc_inc     = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge clr_i) begin
    if (!clr_i) begin
      state_q    <= ST_IDLE;
      ir_valid_q <= 1'b0;
      ir_data_q  <= '0;
      ir_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      ir_valid_q <= ir_valid_d;
      if (ir_load) begin
        ir_data_q <= ram_data_i;
        ir_pc_q   <= pc;
      end
    end
  end

  assign ram_enab_o = (state_q == ST_FETCH);
  assign ram_rw_o   = RAM_READ;
  assign ram_addr_o = pc;
  assign ir_valid_o = ir_valid_q;
  assign ir_data_o  = ir_data_q;
  assign ir_pc_o    = ir_pc_q;
  assign pc_out_o   = pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch with a registered-read program RAM and a cycle-timeline reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        clr;
  logic        ram_enab, ram_rw;
  logic [7:0]  ram_addr;
  logic [15:0] ram_q;
  logic        halt, jmp_en, ir_ready;
  logic [7:0]  jmp_addr;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [7:0]  ir_pc, pc_out;

  logic [15:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  // Model: pc, the IR contents, and how many edges remain until the IR loads (-1 = idle).
  int          m_pc, m_cnt, m_irpc;
  bit          m_valid;
  logic [15:0] m_data;

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= ram_enab ? mem[ram_addr] : 16'h0055;

  instr_fetch #(.D_WIDTH(16), .A_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk_i      (clk),
    .clr_i      (clr),
    .ram_enab_o (ram_enab),
    .ram_rw_o   (ram_rw),
    .ram_addr_o (ram_addr),
    .ram_data_i (ram_q),
    .halt_i     (halt),
    .jmp_en_i   (jmp_en),
    .jmp_addr_i (jmp_addr),
    .ir_valid_o (ir_valid),
    .ir_ready_i (ir_ready),
    .ir_data_o  (ir_data),
    .ir_pc_o    (ir_pc),
    .pc_out_o   (pc_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_cnt = -1; m_valid = 0; m_data = 16'h0000; m_irpc = 0;
  endtask

  // One clock edge: a word appears two edges after a fetch starts; from idle it takes three.
  task automatic model_step();
    if (jmp_en) begin
      m_pc = jmp_addr; m_valid = 0; m_cnt = halt ? -1 : 2;
    end else if (m_valid) begin
      if (ir_ready) begin
        m_valid = 0; m_pc = (m_pc + 1) % 256; m_cnt = halt ? -1 : 2;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1; m_data = mem[m_pc]; m_irpc = m_pc;
      end
    end else if (!halt) begin
      m_cnt = 2;
    end
  endtask

  task automatic check_outputs();
    check("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
    check("ram_enab", {31'b0, ram_enab}, {31'b0, (m_cnt == 2 && !m_valid)});
    check("ram_rw",   {31'b0, ram_rw}, 32'd0);
    check("ram_addr", {24'b0, ram_addr}, m_pc);
    check("pc_out",   {24'b0, pc_out}, m_pc);
    check("ir_data",  {16'b0, ir_data}, {16'b0, m_data});
    check("ir_pc",    {24'b0, ir_pc}, m_irpc);
  endtask

  task automatic cyc(input bit rdy, input bit hlt, input bit jen, input logic [7:0] ja);
    ir_ready = rdy; halt = hlt; jmp_en = jen; jmp_addr = ja;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h000F; mem[1] = 16'h003F; mem[2] = 16'h007F; mem[3] = 16'h00EF;
    clr = 1'b0; halt = 1'b0; jmp_en = 1'b0; jmp_addr = 8'h00; ir_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    clr = 1'b1;

    // Sequential fetch of the preloaded words with decode always ready.
    for (int k = 0; k < 4; k++) begin
      repeat (3) cyc(1, 0, 0, 8'h00);
      check("seq_valid", {31'b0, ir_valid}, 32'd1);
      check("seq_data",  {16'b0, ir_data}, {16'b0, mem[k]});
      check("seq_pc",    {24'b0, ir_pc}, k);
    end

    // Decode stalls in HOLD, then releases.
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    repeat (5) cyc(0, 0, 0, 8'h00);
    repeat (4) cyc(1, 0, 0, 8'h00);

    // Jump to 3 while address 1 is in WAIT: its word must never show up.
    cyc(0, 0, 1, 8'h01);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h03);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    check("jmp_data", {16'b0, ir_data}, 32'h00EF);
    check("jmp_pc",   {24'b0, ir_pc}, 32'd3);

    // PC wrap from 0xFF.
    cyc(0, 0, 1, 8'hFF);
    repeat (2) cyc(0, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    check("wrap_addr", {24'b0, ram_addr}, 32'd0);
    repeat (2) cyc(0, 0, 0, 8'h00);
    check("wrap_irpc", {24'b0, ir_pc}, 32'd0);

    // Halt raised in FETCH: word still completes, then the stage idles.
    cyc(0, 0, 1, 8'h10);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    cyc(1, 1, 0, 8'h00);
    repeat (3) cyc(0, 1, 0, 8'h00);
    check("halt_enab", {31'b0, ram_enab}, 32'd0);
    repeat (4) cyc(1, 0, 0, 8'h00);

    // Asynchronous reset in the middle of WAIT.
    cyc(0, 0, 1, 8'h02);
    cyc(0, 0, 0, 8'h00);
    #2 clr = 1'b0;
    #1 model_reset();
    check("arst_valid", {31'b0, ir_valid}, 32'd0);
    check("arst_pc",    {24'b0, pc_out}, 32'd0);
    @(negedge clk);
    check_outputs();
    clr = 1'b1;
    repeat (3) cyc(1, 0, 0, 8'h00);
    check("arst_data", {16'b0, ir_data}, 32'h000F);

    // Random traffic: stalls, halts and jumps.
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 15) == 0, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
